serial_adder: RTL

Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and adds them LSB-first, one bit per clock. Each bit uses a single carry flip-flop and a full-adder slice built from two half-adder cells. The block sits directly downstream of the half-adder primitive and is the first sequential arithmetic stage in the datapath. It trades WIDTH cycles of latency for a one-bit adder footprint.

---
 rtl/serial_adder.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in LSB-first, one bit per clock,
// using a single carry flop and a full adder made of two half-adder slices.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;

   logic             w_ha0_s;
   logic             w_ha0_c;
   logic             w_ha1_c;
   logic             w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_res_next;
   logic             w_last;

   // Full adder = half adder on the operand bits, then half adder with the carry.
   assign w_ha0_s    = r_a[0] ^ r_b[0];
   assign w_ha0_c    = r_a[0] & r_b[0];
   assign w_s        = w_ha0_s ^ r_carry;
   assign w_ha1_c    = w_ha0_s & r_carry;
   assign w_c        = w_ha0_c | w_ha1_c;
   assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_res   <= '0;
                  r_state <= S_ADD;
               end
            end
            S_ADD: begin
               r_res   <= w_res_next;
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_c;
               r_cnt   <= r_cnt + 1'b1;
               // Visible outputs change only when the final bit lands.
               if (w_last) begin
                  r_sum   <= w_res_next;
                  r_cout  <= w_c;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Handshake: a transfer happens on any rising edge where valid && ready are both high;
   // in_ready/out_valid/busy depend on state only.
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule
